multdiv_sched: RTL and testbench
================================

MULTDIV_SCHED -- requirements
Module: multdiv_sched

Interface
REQ-001 Parameter: LAT, default 16, index of the last in-flight stage; the block tracks LAT+1 stages.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 issue_valid  in  1  X stage holds a mul/div and the pipeline is advancing it this cycle.
REQ-005 issue_is_div  in  1  1 = divide (may raise exception), 0 = multiply.
REQ-006 issue_rd  in  5  destination register of the issuing op.
REQ-007 x_rd, x_rs, x_rt  in  5 each  register fields of the instruction currently in X.
REQ-008 x_reads_rd, x_reads_rs, x_reads_rt  in  1 each  X actually reads that field.
REQ-009 x_is_bex  in  1  X holds bex.
REQ-010 wb_free  in  1  MW slot is a NOP this cycle; the writeback port is available.
REQ-011 issue_ready  out  1  op can be accepted this cycle.
REQ-012 md_start  out  1  one-cycle start pulse to the multdiv datapath.
REQ-013 md_freeze  out  1  freezes the multdiv datapath pipeline.
REQ-014 busy_stage  out  LAT+1  per-stage valid bits.
REQ-015 bp_req  out  LAT+1  per-stage RAW hit against X.
REQ-016 data_req  out  1  OR of bp_req[LAT-1:0]; X must stall.
REQ-017 exc_piped  out  1  a divide is in flight.
REQ-018 wait_exc  out  1  exc_piped AND x_is_bex.
REQ-019 wb_valid, wb_rd (5), wb_is_div  out  writeback request from stage LAT.
REQ-020 occupancy  out  5  count of valid stages, range 0..LAT+1.

Function
REQ-021 Each stage s holds valid, rd[4:0] and is_div.
REQ-022 freeze = valid[LAT] AND NOT wb_free.
REQ-023 md_freeze SHALL equal freeze.
REQ-024 When not frozen, every stage SHALL shift from s to s+1 each cycle.
REQ-025 While frozen, all stages SHALL hold their contents.
REQ-026 When not frozen, stage LAT SHALL retire: wb_valid = valid[LAT] AND wb_free.
REQ-027 waw = issue_rd equals rd of any valid stage, with issue_rd != 0.
REQ-028 issue_ready = NOT freeze AND NOT waw.
REQ-029 accept = issue_valid AND issue_ready; on accept, stage 0 loads {1, issue_rd, issue_is_div}; otherwise stage 0 loads valid=0 when not frozen.
REQ-030 md_start SHALL equal accept, combinationally in the same cycle.
REQ-031 At most one issue SHALL be accepted per cycle.
REQ-032 issue_valid while issue_ready=0 SHALL be ignored; upstream holds the op until accepted.
REQ-033 bp_req[s] = valid[s] AND rd[s]!=0 AND ((x_reads_rd AND x_rd==rd[s]) OR (x_reads_rs AND x_rs==rd[s]) OR (x_reads_rt AND x_rt==rd[s])).
REQ-034 bp_req[LAT] is excluded from data_req, because that result is forwarded on writeback.
REQ-035 An op with rd=0 SHALL be tracked and retired but SHALL never raise bp_req or waw.
REQ-036 exc_piped = OR over s of (valid[s] AND is_div[s]).
REQ-037 occupancy: +1 on accept; -1 on retire; unchanged when both occur or neither occurs.
REQ-038 occupancy SHALL never exceed LAT+1 or wrap below 0.
REQ-039 wb_rd and wb_is_div SHALL mirror stage LAT whenever valid[LAT]=1; they are 0 otherwise.

Reset
REQ-040 On reset assertion all valid, rd, is_div and occupancy SHALL clear immediately, independent of clock.
REQ-041 While reset is asserted, all outputs SHALL be 0, except issue_ready, which reads 1.
REQ-042 In-flight ops at reset SHALL be discarded without writeback.
REQ-043 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-044 Issue mul rd=5 at cycle 0, wb_free=1 throughout:
- busy_stage[k]=1 at cycle k;
- wb_valid=1 with wb_rd=5 at cycle 16;
- occupancy returns to 0 at cycle 17.
REQ-045 Issue rd=5, then present X with x_reads_rs=1, x_rs=5:
- data_req=1 while the op is in stages 0..15;
- data_req=0 when it reaches stage 16;
- with rd=0 instead, data_req stays 0 throughout.
REQ-046 Op reaches stage 16 with wb_free=0 for 3 cycles:
- md_freeze=1 and issue_ready=0 for those 3 cycles;
- busy_stage is unchanged;
- wb_valid pulses on the cycle wb_free returns to 1.
REQ-047 Issue div rd=7, then present X with x_is_bex=1:
- exc_piped=1 and wait_exc=1 until the div retires;
- a mul-only pipeline gives exc_piped=0.
REQ-048 rd=9 in flight, then a second issue with rd=9:
- issue_ready=0 and md_start=0 until the first op retires;
- issue with rd=10 is accepted immediately.
REQ-049 Back-to-back issue every cycle for 17 cycles, then assert reset mid-stream:
- occupancy=17 before reset;
- all busy_stage bits 0 immediately on reset;
- no wb_valid pulse after reset.

Source files
------------

// File: rtl/multdiv_sched.sv
// multdiv_sched: tracks mul/div ops as they move through the multdiv datapath.
// It holds per-stage valid/rd/is_div, raises bypass and WAW hazards, reports
// in-flight divides for bex, and drives the writeback request from the last stage.
module multdiv_sched #(
  parameter int LAT = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic           issue_is_div,
  input  logic [4:0]     issue_rd,
  input  logic [4:0]     x_rd,
  input  logic [4:0]     x_rs,
  input  logic [4:0]     x_rt,
  input  logic           x_reads_rd,
  input  logic           x_reads_rs,
  input  logic           x_reads_rt,
  input  logic           x_is_bex,
  input  logic           wb_free,
  output logic           issue_ready,
  output logic           md_start,
  output logic           md_freeze,
  output logic [LAT:0]   busy_stage,
  output logic [LAT:0]   bp_req,
  output logic           data_req,
  output logic           exc_piped,
  output logic           wait_exc,
  output logic           wb_valid,
  output logic [4:0]     wb_rd,
  output logic           wb_is_div,
  output logic [4:0]     occupancy
);

  logic [LAT:0]      valid_q, valid_d;
  logic [LAT:0][4:0] rd_q, rd_d;
  logic [LAT:0]      is_div_q, is_div_d;
  logic [4:0]        occ_q, occ_d;

  logic freeze;
  logic waw;
  logic accept;
  logic retire;
  logic exc_any;
  logic [LAT:0] bp_hit;

  // The last stage can only leave when the writeback port is free; otherwise
  // the whole tracker and the datapath hold.
  assign freeze      = valid_q[LAT] & ~wb_free;
  assign retire      = valid_q[LAT] & wb_free;
  assign issue_ready = ~freeze & ~waw;
  assign accept      = issue_valid & issue_ready;

  // Hazard scan across every stage: WAW for the issuing op, RAW for X, divides in flight.
  always_comb begin
    waw     = 1'b0;
    exc_any = 1'b0;
    bp_hit  = '0;
    for (int s = 0; s <= LAT; s++) begin
      if (valid_q[s] && (rd_q[s] == issue_rd) && (issue_rd != 5'd0)) begin
        waw = 1'b1;
      end
      if (valid_q[s] && is_div_q[s]) begin
        exc_any = 1'b1;
      end
      if (valid_q[s] && (rd_q[s] != 5'd0) &&
          ((x_reads_rd && (x_rd == rd_q[s])) ||
           (x_reads_rs && (x_rs == rd_q[s])) ||
           (x_reads_rt && (x_rt == rd_q[s])))) begin
        bp_hit[s] = 1'b1;
      end
    end
  end

  // Shift every stage forward unless frozen; stage 0 takes the accepted op or a bubble.
  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    if (!freeze) begin
      for (int s = LAT; s > 0; s--) begin
        valid_d[s]  = valid_q[s-1];
        rd_d[s]     = rd_q[s-1];
        is_div_d[s] = is_div_q[s-1];
      end
      valid_d[0]  = accept;
      rd_d[0]     = accept ? issue_rd : 5'd0;
      is_div_d[0] = accept & issue_is_div;
    end
  end

  // Occupancy moves by one on accept or retire and stays put when both or neither happen.
  always_comb begin
    occ_d = occ_q;
    if (accept && !retire) begin
      occ_d = occ_q + 5'd1;
    end else if (!accept && retire) begin
      occ_d = occ_q - 5'd1;
    end
  end

  // Stage and occupancy registers; reset drops every in-flight op without writeback.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rd_q     <= '0;
      is_div_q <= '0;
      occ_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      occ_q    <= occ_d;
    end
  end

  // The start pulse is masked during reset so nothing launches while state is held clear.
  assign md_start   = accept & ~reset;
  assign md_freeze  = freeze;
  assign busy_stage = valid_q;
  assign bp_req     = bp_hit;
  assign data_req   = |bp_hit[LAT-1:0];
  assign exc_piped  = exc_any;
  assign wait_exc   = exc_any & x_is_bex;
  assign wb_valid   = retire;
  assign wb_rd      = valid_q[LAT] ? rd_q[LAT] : 5'd0;
  assign wb_is_div  = valid_q[LAT] & is_div_q[LAT];
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_multdiv_sched.sv
// tb_multdiv_sched: directed steps for the mul/div scheduler, with a writeback
// scoreboard fed at issue time and drained whenever the DUT requests writeback.
module tb_multdiv_sched;

  localparam int LAT = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic           issue_valid, issue_is_div;
  logic [4:0]     issue_rd, x_rd, x_rs, x_rt;
  logic           x_reads_rd, x_reads_rs, x_reads_rt, x_is_bex, wb_free;
  logic           issue_ready, md_start, md_freeze, data_req, exc_piped, wait_exc;
  logic [LAT:0]   busy_stage, bp_req;
  logic           wb_valid, wb_is_div;
  logic [4:0]     wb_rd, occupancy;

  typedef struct packed {
    logic [4:0] rd;
    logic       is_div;
  } wb_t;

  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  multdiv_sched #(.LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .x_rd(x_rd), .x_rs(x_rs), .x_rt(x_rt),
    .x_reads_rd(x_reads_rd), .x_reads_rs(x_reads_rs), .x_reads_rt(x_reads_rt),
    .x_is_bex(x_is_bex), .wb_free(wb_free),
    .issue_ready(issue_ready), .md_start(md_start), .md_freeze(md_freeze),
    .busy_stage(busy_stage), .bp_req(bp_req), .data_req(data_req),
    .exc_piped(exc_piped), .wait_exc(wait_exc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_is_div(wb_is_div),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the issue port, let it settle, check the handshake and record the expected writeback.
  task automatic applyStimulus(input logic v, input logic d, input logic [4:0] rd, input logic exp_acc);
    wb_t e;
    issue_valid  = v;
    issue_is_div = d;
    issue_rd     = rd;
    #1;
    checkOutput("md_start", {31'd0, md_start}, {31'd0, exp_acc});
    if (v) checkOutput("issue_ready", {31'd0, issue_ready}, {31'd0, exp_acc});
    if (exp_acc) begin
      e.rd     = rd;
      e.is_div = d;
      sb.push_back(e);
    end
  endtask

  // One clock: drain the scoreboard on the falling edge, then move just past the rising edge.
  task automatic step();
    wb_t e;
    @(negedge clock);
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("wb_spurious", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        checkOutput("wb_is_div", {31'd0, wb_is_div}, {31'd0, e.is_div});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_rd     = 5'd0;
    #1;
  endtask

  initial begin
    logic [LAT:0] onehot;
    reset = 1'b1;
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd3;
    x_rd = '0; x_rs = '0; x_rt = '0;
    x_reads_rd = 1'b0; x_reads_rs = 1'b0; x_reads_rt = 1'b0;
    x_is_bex = 1'b0; wb_free = 1'b1;
    #2;
    // Reset values with an issue request pending.
    checkOutput("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("rst_md_start", {31'd0, md_start}, 32'd0);
    checkOutput("rst_busy", {15'd0, busy_stage}, 32'd0);
    checkOutput("rst_occ", {27'd0, occupancy}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    idle();
    @(posedge clock); #1;
    reset = 1'b0;
    #1;

    // Single mul rd=5 walks all stages and retires at the last one.
    $display("[TB] single mul walk");
    applyStimulus(1'b1, 1'b0, 5'd5, 1'b1);
    step(); idle();
    for (int k = 0; k <= LAT; k++) begin
      onehot = '0; onehot[k] = 1'b1;
      checkOutput("walk_busy", {15'd0, busy_stage}, {15'd0, onehot});
      checkOutput("walk_occ", {27'd0, occupancy}, 32'd1);
      checkOutput("walk_wb_valid", {31'd0, wb_valid}, (k == LAT) ? 32'd1 : 32'd0);
      if (k == LAT) checkOutput("walk_wb_rd", {27'd0, wb_rd}, 32'd5);
      step();
    end
    checkOutput("walk_occ_end", {27'd0, occupancy}, 32'd0);

    // RAW against X: stalls until the op reaches the forwarding stage.
    $display("[TB] raw bypass");
    x_reads_rs = 1'b1; x_rs = 5'd5;
    applyStimulus(1'b1, 1'b0, 5'd5, 1'b1);
    checkOutput("raw_pre", {31'd0, data_req}, 32'd0);
    step(); idle();
    for (int k = 0; k <= LAT; k++) begin
      onehot = '0; onehot[k] = 1'b1;
      checkOutput("raw_data_req", {31'd0, data_req}, (k < LAT) ? 32'd1 : 32'd0);
      checkOutput("raw_bp_req", {15'd0, bp_req}, {15'd0, onehot});
      step();
    end

    // rd=0 never hazards, and two rd=0 ops may issue back to back.
    $display("[TB] rd zero");
    x_rs = 5'd0; x_reads_rd = 1'b1; x_rd = 5'd0;
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1);
    step(); idle();
    for (int k = 0; k <= LAT; k++) begin
      checkOutput("r0_data_req", {31'd0, data_req}, 32'd0);
      checkOutput("r0_bp_req", {15'd0, bp_req}, 32'd0);
      step();
    end
    x_reads_rs = 1'b0; x_reads_rd = 1'b0;
    checkOutput("r0_occ_end", {27'd0, occupancy}, 32'd0);

    // Writeback port busy for three cycles while the op sits in the last stage.
    $display("[TB] freeze");
    applyStimulus(1'b1, 1'b0, 5'd12, 1'b1);
    step(); idle();
    for (int k = 0; k < LAT; k++) step();
    onehot = '0; onehot[LAT] = 1'b1;
    wb_free = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 5'd13, 1'b0);
      checkOutput("frz_md_freeze", {31'd0, md_freeze}, 32'd1);
      checkOutput("frz_busy", {15'd0, busy_stage}, {15'd0, onehot});
      checkOutput("frz_wb_valid", {31'd0, wb_valid}, 32'd0);
      step();
    end
    idle();
    wb_free = 1'b1;
    #1;
    checkOutput("frz_release_freeze", {31'd0, md_freeze}, 32'd0);
    checkOutput("frz_release_wb", {31'd0, wb_valid}, 32'd1);
    checkOutput("frz_release_rd", {27'd0, wb_rd}, 32'd12);
    step();
    checkOutput("frz_occ_end", {27'd0, occupancy}, 32'd0);

    // Divide in flight blocks bex; a mul does not.
    $display("[TB] divide exception");
    x_is_bex = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b1);
    step(); idle();
    for (int k = 0; k <= LAT; k++) begin
      checkOutput("div_exc_piped", {31'd0, exc_piped}, 32'd1);
      checkOutput("div_wait_exc", {31'd0, wait_exc}, 32'd1);
      step();
    end
    checkOutput("div_exc_clear", {31'd0, exc_piped}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd8, 1'b1);
    step(); idle();
    for (int k = 0; k <= LAT; k++) begin
      checkOutput("mul_exc_piped", {31'd0, exc_piped}, 32'd0);
      checkOutput("mul_wait_exc", {31'd0, wait_exc}, 32'd0);
      step();
    end
    x_is_bex = 1'b0;

    // WAW on rd=9 holds the second op; an unrelated rd=10 goes straight in.
    $display("[TB] waw");
    applyStimulus(1'b1, 1'b0, 5'd9, 1'b1);
    step();
    for (int k = 0; k <= LAT; k++) begin
      if (k == 3) applyStimulus(1'b1, 1'b0, 5'd10, 1'b1);
      else        applyStimulus(1'b1, 1'b0, 5'd9, 1'b0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 5'd9, 1'b1);
    step(); idle();
    for (int k = 0; k <= LAT; k++) step();
    checkOutput("waw_occ_end", {27'd0, occupancy}, 32'd0);

    // Fill every stage, then reset mid-stream: everything in flight is dropped.
    $display("[TB] fill and reset");
    for (int i = 0; i <= LAT; i++) begin
      applyStimulus(1'b1, i[0], 5'(i + 1), 1'b1);
      step();
    end
    checkOutput("fill_occ", {27'd0, occupancy}, 32'd17);
    checkOutput("fill_busy", {15'd0, busy_stage}, {15'd0, {(LAT+1){1'b1}}});
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", {15'd0, busy_stage}, 32'd0);
    checkOutput("mid_rst_occ", {27'd0, occupancy}, 32'd0);
    checkOutput("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("mid_rst_md_start", {31'd0, md_start}, 32'd0);
    checkOutput("mid_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    sb.delete();
    idle();
    step(); step();
    reset = 1'b0;
    #1;
    applyStimulus(1'b1, 1'b0, 5'd3, 1'b1);
    step(); idle();
    checkOutput("post_rst_busy", {15'd0, busy_stage}, 32'd1);
    for (int k = 0; k <= LAT + 2; k++) step();

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
